// File: rtl/rs232_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs232_cmd_parser_pkg
// Contents : ASCII character constants and parser state encoding shared by
//            the RS-232 command parser and future ASCII formatters.
// Revision : 1.0 - initial release
// ============================================================================
package rs232_cmd_parser_pkg;

  // Control and framing characters
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_SP = 8'h20;

  // Command letters, both cases
  localparam logic [7:0] C_UW = 8'h57;  // 'W'
  localparam logic [7:0] C_LW = 8'h77;  // 'w'
  localparam logic [7:0] C_UR = 8'h52;  // 'R'
  localparam logic [7:0] C_LR = 8'h72;  // 'r'

  // Line parser states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SP1     = 3'd1,
    S_ADDR    = 3'd2,
    S_SP2     = 3'd3,
    S_DATA    = 3'd4,
    S_EOL     = 3'd5,
    S_ISSUE   = 3'd6,
    S_DISCARD = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_hex2nib.sv
`default_nettype none
// ============================================================================
// Module   : ascii_hex2nib
// Function : Combinational ASCII hex digit decoder. '0'-'9', 'A'-'F' and
//            'a'-'f' yield their nibble value with is_hex=1; any other byte
//            yields nib=0, is_hex=0.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_hex2nib (
  input  logic [7:0] chr,
  output logic [3:0] nib,
  output logic       is_hex
);

  // Range-decode the byte; letters share the low-nibble offset in both cases
  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    if (chr >= 8'h30 && chr <= 8'h39) begin
      nib    = chr[3:0];
      is_hex = 1'b1;
    end else if ((chr >= 8'h41 && chr <= 8'h46) || (chr >= 8'h61 && chr <= 8'h66)) begin
      nib    = chr[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs232_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : rs232_cmd_parser
// Function : Parses "W AAAA DDDD<CR>" and "R AAAA<CR>" hex command lines from
//            the RS-232 character stream and issues each valid line as one
//            req/ack transaction. Malformed lines raise a one-cycle cmd_err.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_cmd_parser #(
  parameter int P_ADDR_NIB = 4,
  parameter int P_DATA_NIB = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_req,
  output logic                    rx_ack,
  output logic                    cmd_req,
  output logic                    cmd_wr,
  output logic [4*P_ADDR_NIB-1:0] cmd_addr,
  output logic [4*P_DATA_NIB-1:0] cmd_data,
  input  logic                    cmd_ack,
  output logic                    cmd_err
);

  import rs232_cmd_parser_pkg::*;

  localparam int C_AW   = 4 * P_ADDR_NIB;
  localparam int C_DW   = 4 * P_DATA_NIB;
  localparam int C_NMAX = (P_ADDR_NIB > P_DATA_NIB) ? P_ADDR_NIB : P_DATA_NIB;
  localparam int C_CW   = $clog2(C_NMAX + 1);

  localparam logic [C_CW-1:0] C_ALAST = C_CW'(P_ADDR_NIB - 1);
  localparam logic [C_CW-1:0] C_DLAST = C_CW'(P_DATA_NIB - 1);

  state_t            r_state;
  logic [C_CW-1:0]   r_cnt;
  logic              r_rx_ack;
  logic              r_cmd_req;
  logic              r_cmd_wr;
  logic [C_AW-1:0]   r_addr;
  logic [C_DW-1:0]   r_data;
  logic              r_cmd_err;

  logic [3:0]        w_nib;
  logic              w_is_hex;
  logic              w_take;

  ascii_hex2nib u_hex (
    .chr    (rx_data),
    .nib    (w_nib),
    .is_hex (w_is_hex)
  );

  // A pending character is consumed only when no ack is in flight for it
  // and no command is waiting downstream
  assign w_take = rx_req && !r_rx_ack && (r_state != S_ISSUE);

  // Line parser: advances one step per accepted character
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rx_ack  <= 1'b0;
      r_cmd_req <= 1'b0;
      r_cmd_wr  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_rx_ack  <= w_take;
      r_cmd_err <= 1'b0;
      if (r_state == S_ISSUE) begin
        if (cmd_ack) begin
          r_cmd_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      end else if (w_take) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == C_UW || rx_data == C_LW ||
                rx_data == C_UR || rx_data == C_LR) begin
              r_cmd_wr <= (rx_data == C_UW || rx_data == C_LW);
              r_addr   <= '0;
              r_data   <= '0;
              r_cnt    <= '0;
              r_state  <= S_SP1;
            end else if (rx_data != C_CR && rx_data != C_LF && rx_data != C_SP) begin
              r_state <= S_DISCARD;
            end
          end
          S_SP1: begin
            if (rx_data == C_SP) begin
              r_state <= S_ADDR;
            end else if (rx_data == C_CR) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_ADDR: begin
            if (w_is_hex) begin
              r_addr <= (r_addr << 4) | C_AW'(w_nib);
              if (r_cnt == C_ALAST) begin
                r_cnt   <= '0;
                r_state <= r_cmd_wr ? S_SP2 : S_EOL;
              end else begin
                r_cnt <= r_cnt + C_CW'(1);
              end
            end else if (rx_data == C_CR) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_SP2: begin
            if (rx_data == C_SP) begin
              r_state <= S_DATA;
            end else if (rx_data == C_CR) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_DATA: begin
            if (w_is_hex) begin
              r_data <= (r_data << 4) | C_DW'(w_nib);
              if (r_cnt == C_DLAST) begin
                r_cnt   <= '0;
                r_state <= S_EOL;
              end else begin
                r_cnt <= r_cnt + C_CW'(1);
              end
            end else if (rx_data == C_CR) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_EOL: begin
            if (rx_data == C_CR) begin
              r_cmd_req <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (rx_data == C_CR) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ack   = r_rx_ack;
  assign cmd_req  = r_cmd_req;
  assign cmd_wr   = r_cmd_wr;
  assign cmd_addr = r_addr;
  assign cmd_data = r_data;
  assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_rs232_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_cmd_parser
// Function : Self-checking bench for rs232_cmd_parser: directed lines plus
//            randomized lines checked against a line-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_cmd_parser;

  typedef logic [7:0] bq_t[$];

  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_SP = 8'h20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_req;
  logic        rx_ack;
  logic        cmd_req;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        cmd_err;

  int checks = 0;
  int failures = 0;
  int exp_errs = 0;
  int exp_cmds = 0;

  // Event monitor results
  int   err_pulses = 0;
  int   req_rises = 0;
  int   stab_viol = 0;
  int   ack_viol = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_wr = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [15:0] prev_data = 16'h0;

  rs232_cmd_parser #(.P_ADDR_NIB(4), .P_DATA_NIB(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_req   (rx_req),
    .rx_ack   (rx_ack),
    .cmd_req  (cmd_req),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_ack  (cmd_ack),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Count error pulses and command issues; flag field changes during a request
  always @(negedge clk) begin
    if (cmd_err) err_pulses <= err_pulses + 1;
    if (cmd_req && !prev_req) req_rises <= req_rises + 1;
    if (cmd_req && prev_req &&
        (cmd_wr !== prev_wr || cmd_addr !== prev_addr || cmd_data !== prev_data))
      stab_viol <= stab_viol + 1;
    if (rx_ack && prev_ack) ack_viol <= ack_viol + 1;
    prev_req  <= cmd_req;
    prev_ack  <= rx_ack;
    prev_wr   <= cmd_wr;
    prev_addr <= cmd_addr;
    prev_data <= cmd_data;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_rx_ack"}, rx_ack, 1'b0);
    chk1({tag, "_cmd_req"}, cmd_req, 1'b0);
    chk1({tag, "_cmd_wr"}, cmd_wr, 1'b0);
    chk16({tag, "_cmd_addr"}, cmd_addr, 16'h0000);
    chk16({tag, "_cmd_data"}, cmd_data, 16'h0000);
    chk1({tag, "_cmd_err"}, cmd_err, 1'b0);
  endtask

  // ---------------- reference model ----------------
  function automatic int hexval(input logic [7:0] c);
    string      digs = "0123456789abcdef";
    logic [7:0] lc;
    lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
    for (int i = 0; i < 16; i++) if (digs[i] == lc) return i;
    return -1;
  endfunction

  // Outcome of one line (body without its terminating CR)
  function automatic void model(input bq_t q, output bit is_cmd, output bit is_err,
                                output bit wr, output logic [15:0] a, output logic [15:0] d);
    bq_t b;
    bit  ok;
    int  n;
    b = q;
    is_cmd = 1'b0; is_err = 1'b0; wr = 1'b0; a = 16'h0; d = 16'h0;
    while (b.size() > 0 && (b[0] == C_SP || b[0] == C_LF)) void'(b.pop_front());
    if (b.size() == 0) return;
    ok = 1'b1;
    wr = (b[0] == 8'h57 || b[0] == 8'h77);
    if (!wr && b[0] != 8'h52 && b[0] != 8'h72) ok = 1'b0;
    n = wr ? 11 : 6;
    if (b.size() != n) ok = 1'b0;
    if (ok) begin
      if (b[1] != C_SP) ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (hexval(b[2+i]) < 0) ok = 1'b0;
        else a = 16'(a * 16 + hexval(b[2+i]));
      end
      if (wr) begin
        if (b[6] != C_SP) ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (hexval(b[7+i]) < 0) ok = 1'b0;
          else d = 16'(d * 16 + hexval(b[7+i]));
        end
      end
    end
    is_cmd = ok;
    is_err = !ok;
    if (!ok) begin wr = 1'b0; a = 16'h0; d = 16'h0; end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] rhex();
    int v;
    v = int'($urandom_range(0, 15));
    if (v < 10) return 8'(48 + v);
    return ($urandom_range(0, 1) == 1) ? 8'(55 + v) : 8'(87 + v);
  endfunction

  function automatic bq_t gen_line();
    bq_t q;
    bit  w;
    int  p;
    w = ($urandom_range(0, 1) == 1);
    repeat ($urandom_range(0, 2)) q.push_back(($urandom_range(0, 1) == 1) ? C_SP : C_LF);
    if (w) q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h77);
    else   q.push_back(($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72);
    q.push_back(C_SP);
    repeat (4) q.push_back(rhex());
    if (w) begin
      q.push_back(C_SP);
      repeat (4) q.push_back(rhex());
    end
    p = int'($urandom_range(0, q.size() - 1));
    case ($urandom_range(0, 5))
      0: q[p] = 8'($urandom_range(32, 126));
      1: q.delete(p);
      2: q.insert(p, rhex());
      default: ;
    endcase
    return q;
  endfunction

  // Present one character and wait for its acceptance
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    rx_data = c;
    rx_req  = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rx_ack && n < 20);
    rx_req = 1'b0;
    chk1("rx_ack_seen", rx_ack, 1'b1);
  endtask

  // Send body + CR, check the outcome against the model, ack any command
  task automatic run_line(input bq_t body, input int hold);
    bit          is_cmd, is_err, wr;
    logic [15:0] a, d;
    model(body, is_cmd, is_err, wr, a, d);
    foreach (body[i]) begin
      send_char(body[i]);
      chk1("mid_err", cmd_err, 1'b0);
      chk1("mid_req", cmd_req, 1'b0);
    end
    send_char(C_CR);
    chk1("eol_req", cmd_req, is_cmd);
    chk1("eol_err", cmd_err, is_err);
    if (is_err) exp_errs++;
    if (is_cmd) begin
      exp_cmds++;
      chk1("cmd_wr", cmd_wr, wr);
      chk16("cmd_addr", cmd_addr, a);
      chk16("cmd_data", cmd_data, d);
      repeat (hold) begin
        @(posedge clk); #1;
        chk1("hold_req", cmd_req, 1'b1);
        chk1("hold_wr", cmd_wr, wr);
        chk16("hold_addr", cmd_addr, a);
        chk16("hold_data", cmd_data, d);
      end
      cmd_ack = 1'b1;
      @(posedge clk); #1;
      cmd_ack = 1'b0;
      chk1("ack_drop", cmd_req, 1'b0);
    end else begin
      @(posedge clk); #1;
      chk1("err_one_cycle", cmd_err, 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   nack;
    bq_t  tmp;
    rst_n   = 1'b0;
    rx_req  = 1'b0;
    rx_data = 8'h00;
    cmd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write with mixed-case hex, downstream stalls 20 cycles
    run_line(str2q("W 1A2b C0DE"), 20);

    // Read, trailing LF absorbed silently
    run_line(str2q("r 00fF"), 0);
    send_char(C_LF);
    chk1("lf_err", cmd_err, 1'b0);
    chk1("lf_req", cmd_req, 1'b0);
    @(posedge clk); #1;
    chk1("lf_err_late", cmd_err, 1'b0);

    // Bad hex digit, then a good read
    run_line(str2q("W 12G4 5678"), 0);
    run_line(str2q("R 0001"), 2);

    // Early CR and extra digit
    run_line(str2q("R 12"), 0);
    run_line(str2q("R 12345"), 0);

    // Request held across the ack cycle must be taken only once
    rx_data = 8'h52;
    rx_req  = 1'b1;
    nack    = 0;
    @(posedge clk); #1; if (rx_ack) nack++;
    @(posedge clk); #1; if (rx_ack) nack++;
    rx_req = 1'b0;
    @(posedge clk); #1; if (rx_ack) nack++;
    chki("hs_ack_count", nack, 1);
    tmp = str2q(" 5A5A");
    foreach (tmp[i]) send_char(tmp[i]);
    send_char(C_CR);
    chk1("hs_req", cmd_req, 1'b1);
    chk1("hs_wr", cmd_wr, 1'b0);
    chk16("hs_addr", cmd_addr, 16'h5A5A);
    chk16("hs_data", cmd_data, 16'h0000);
    exp_cmds++;
    cmd_ack = 1'b1;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
    chk1("hs_ack_drop", cmd_req, 1'b0);

    // Reset in the middle of a line
    tmp = str2q("W 12");
    foreach (tmp[i]) send_char(tmp[i]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_line(str2q("R ABCD"), 1);

    // Randomized lines against the reference model
    for (int k = 0; k < 40; k++) run_line(gen_line(), int'($urandom_range(0, 4)));

    repeat (2) @(posedge clk);
    #1;
    chki("total_err_pulses", err_pulses, exp_errs);
    chki("total_cmd_issues", req_rises, exp_cmds);
    chki("field_stability", stab_viol, 0);
    chki("rx_ack_width", ack_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
